mem_cache_controller: RTL and testbench

Sequencing FSM for the MEM-stage data cache. It turns the pipeline's load/store request and the cache's hit/dirty status into the per-cycle cache and memory control strobes: `we_cache`, `we_memory`, `cache_input_type`, `set_dirty`, `set_valid` and `memory_address_type`. It also raises `stall` to freeze the pipeline while a miss is serviced. The block sits beside the MEM stage and drives its control inputs directly; main memory is fixed-latency.

---
 rtl/mem_cache_controller.sv | 124 ++++++++++++
 tb/tb_mem_cache_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_cache_controller.sv
// MEM-stage data cache sequencer: hit/miss control strobes, dirty write-back and line fill.
// Optional MEM_CTRL_PERF_EN adds hit/miss/write-back performance counters.
module mem_cache_controller #(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        halted,
    input  logic        cache_hit,
    input  logic        cache_dirty,
    output logic        we_cache,
    output logic        we_memory,
    output logic        cache_input_type,
    output logic        set_dirty,
    output logic        set_valid,
    output logic        memory_address_type,
    output logic        stall
`ifdef MEM_CTRL_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] writeback_count
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    localparam logic [3:0] LOAD = 4'(MEM_LATENCY - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       req;

    assign req = (mem_read | mem_write) & ~halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Outputs are forced low while reset is asserted, including the Mealy IDLE strobes.
    always_comb begin
        state_nx            = state;
        cnt_nx              = cnt;
        we_cache            = 1'b0;
        we_memory           = 1'b0;
        cache_input_type    = 1'b0;
        set_dirty           = 1'b0;
        set_valid           = 1'b0;
        memory_address_type = 1'b0;
        stall               = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (cache_hit) begin
                            if (mem_write) begin
                                we_cache         = 1'b1;
                                cache_input_type = 1'b1;
                                set_dirty        = 1'b1;
                                set_valid        = 1'b1;
                            end
                        end else begin
                            stall    = 1'b1;
                            cnt_nx   = LOAD;
                            state_nx = cache_dirty ? WRITEBACK : FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    stall               = 1'b1;
                    memory_address_type = 1'b1;
                    if (cnt == 4'd0) begin
                        we_memory = 1'b1;
                        cnt_nx    = LOAD;
                        state_nx  = FILL;
                    end else begin
                        cnt_nx = cnt - 4'd1;
                    end
                end
                FILL: begin
                    stall = 1'b1;
                    if (cnt == 4'd0) begin
                        we_cache  = 1'b1;
                        set_valid = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        cnt_nx = cnt - 4'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

`ifdef MEM_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count       <= 32'd0;
            miss_count      <= 32'd0;
            writeback_count <= 32'd0;
        end else begin
            if (state == IDLE && req && cache_hit)
                hit_count <= hit_count + 32'd1;
            if (state == IDLE && req && !cache_hit)
                miss_count <= miss_count + 32'd1;
            if (we_memory)
                writeback_count <= writeback_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_cache_controller.sv
// Self-checking bench for mem_cache_controller: directed test-plan sequences plus randomized traffic
// against a schedule-based model of the miss sequence.
module tb_mem_cache_controller;

    localparam int L = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_read = 1'b0, mem_write = 1'b0, halted = 1'b0, cache_hit = 1'b0, cache_dirty = 1'b0;
    logic we_cache, we_memory, cache_input_type, set_dirty, set_valid, memory_address_type, stall;
`ifdef MEM_CTRL_PERF_EN
    logic [31:0] hit_count, miss_count, writeback_count;
`endif

    mem_cache_controller #(.MEM_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .halted(halted),
        .cache_hit(cache_hit), .cache_dirty(cache_dirty), .we_cache(we_cache), .we_memory(we_memory),
        .cache_input_type(cache_input_type), .set_dirty(set_dirty), .set_valid(set_valid),
        .memory_address_type(memory_address_type), .stall(stall)
`ifdef MEM_CTRL_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count), .writeback_count(writeback_count)
`endif
    );

    // ---- clock ----
    always #5 clk = ~clk;

    // Output vector: {we_cache, we_memory, cache_input_type, set_dirty, set_valid, memory_address_type, stall}
    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_WHIT  = 7'b1011100;
    localparam logic [6:0] O_STALL = 7'b0000001;
    localparam logic [6:0] O_WB    = 7'b0000011;
    localparam logic [6:0] O_WBMEM = 7'b0100011;
    localparam logic [6:0] O_FILLW = 7'b1000101;

    int errors = 0;
    int checks = 0;

    function automatic logic [6:0] outs();
        return {we_cache, we_memory, cache_input_type, set_dirty, set_valid, memory_address_type, stall};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---- scoreboard: future cycles of an in-flight miss are queued; IDLE outputs follow inputs ----
    logic [6:0] exp_q[$];
    logic [31:0] m_hit = 0, m_miss = 0, m_wb = 0;

    always @(negedge clk) begin
        logic [6:0] exp;
`ifdef MEM_CTRL_PERF_EN
        chk("hit_count", hit_count, m_hit);
        chk("miss_count", miss_count, m_miss);
        chk("writeback_count", writeback_count, m_wb);
`endif
        if (!rst_n) begin
            exp_q.delete();
            m_hit = 0; m_miss = 0; m_wb = 0;
            exp = O_NONE;
        end else if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            if (exp[5]) m_wb++;
        end else if (!((mem_read || mem_write) && !halted)) begin
            exp = O_NONE;
        end else if (cache_hit) begin
            m_hit++;
            exp = mem_write ? O_WHIT : O_NONE;
        end else begin
            m_miss++;
            exp = O_STALL;
            if (cache_dirty)
                for (int i = 0; i < L; i++) exp_q.push_back(i == L - 1 ? O_WBMEM : O_WB);
            for (int i = 0; i < L; i++) exp_q.push_back(i == L - 1 ? O_FILLW : O_STALL);
        end
        chk("outputs", {25'd0, outs()}, {25'd0, exp});
    end

    // ---- driver ----
    task automatic step(input logic r, input logic w, input logic h, input logic hit, input logic d);
        @(posedge clk); #1;
        mem_read = r; mem_write = w; halted = h; cache_hit = hit; cache_dirty = d;
        @(negedge clk); #1;
    endtask

    logic [6:0] clean_tbl [5];
    logic [6:0] dirty_tbl [10];

    initial begin
`ifdef MEM_CTRL_PERF_EN
        logic [31:0] h0, m0, w0;
`endif
        clean_tbl = '{O_STALL, O_STALL, O_STALL, O_STALL, O_FILLW};
        dirty_tbl = '{O_STALL, O_WB, O_WB, O_WB, O_WBMEM, O_STALL, O_STALL, O_STALL, O_FILLW, O_WHIT};

        // Reset held with toggling inputs: everything stays low.
        for (int i = 0; i < 6; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk("reset_outs", {25'd0, outs()}, 32'd0);
        end
        step(0, 1, 0, 1, 0);
        chk("reset_write_hit", {25'd0, outs()}, 32'd0);

        // Release reset, read hits: no stall, no strobes.
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 0);
            chk("read_hit", {25'd0, outs()}, 32'd0);
        end

        step(0, 1, 0, 1, 0);
        chk("write_hit", {25'd0, outs()}, {25'd0, O_WHIT});
        step(1, 1, 0, 1, 1);
        chk("rw_hit_is_write", {25'd0, outs()}, {25'd0, O_WHIT});
        step(0, 1, 1, 0, 1);
        chk("halted_no_req", {25'd0, outs()}, 32'd0);

        // Clean read miss: 5 stall cycles, fill strobe on the 5th.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0);
            chk($sformatf("clean_miss_c%0d", i + 1), {25'd0, outs()}, {25'd0, clean_tbl[i]});
        end
        step(1, 0, 0, 1, 0);
        chk("clean_retry", {25'd0, outs()}, 32'd0);

        // Dirty write miss: write-back, fill, then retry write hit.
`ifdef MEM_CTRL_PERF_EN
        h0 = m_hit; m0 = m_miss; w0 = m_wb;
`endif
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, i == 9, 1);
            chk($sformatf("dirty_miss_c%0d", i + 1), {25'd0, outs()}, {25'd0, dirty_tbl[i]});
        end
        step(0, 0, 0, 0, 0);
`ifdef MEM_CTRL_PERF_EN
        chk("perf_miss_delta", miss_count - m0, 32'd1);
        chk("perf_wb_delta", writeback_count - w0, 32'd1);
        chk("perf_hit_delta", hit_count - h0, 32'd1);
`endif

        // Reset during FILL cycle 2 abandons the transfer immediately.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("fill_c2_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {25'd0, outs()}, 32'd0);
        step(0, 0, 0, 0, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1);
            chk("post_reset_idle", {25'd0, outs()}, 32'd0);
        end
        step(1, 0, 0, 1, 0);
        chk("post_reset_hit", {25'd0, outs()}, 32'd0);

        // Randomized traffic; requests are usually held while a miss is in flight.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
            end else begin
                rst_n = 1'b1;
                if (exp_q.size() == 0 || $urandom_range(0, 9) == 0) begin
                    mem_read  = ($urandom_range(0, 9) < 5);
                    mem_write = ($urandom_range(0, 9) < 4);
                end
                halted      = ($urandom_range(0, 9) == 0);
                cache_hit   = ($urandom_range(0, 9) < 6);
                cache_dirty = 1'($urandom);
            end
        end

        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
